// File: rtl/clstr_mem_arb_pkg.sv
// Shared types and widths for the cluster-memory arbiter slice.
package clstr_mem_arb_pkg;

  localparam int CLSTR_ARB_NUM_PORTS  = 4;
  localparam int CLSTR_ARB_TAG_DEPTH  = 8;

  localparam int CLSTR_IDX_WIDTH      = 16;
  localparam int CLSTR_RID_WIDTH      = 8;
  localparam int CLSTR_DATA_WIDTH     = 32;

  // Request word {cluster_idx, rid}; response word {cluster, rid}.
  localparam int CLSTR_MEM_REQ_WIDTH  = CLSTR_IDX_WIDTH + CLSTR_RID_WIDTH;
  localparam int CLSTR_MEM_RESP_WIDTH = CLSTR_DATA_WIDTH + CLSTR_RID_WIDTH;

  // Tag width for the default port count.
  localparam int CLSTR_ARB_PORT_WIDTH = $clog2(CLSTR_ARB_NUM_PORTS);

  typedef struct packed {
    logic [CLSTR_IDX_WIDTH-1:0] cluster_idx;
    logic [CLSTR_RID_WIDTH-1:0] rid;
  } clstr_mem_req_t;

  typedef struct packed {
    logic [CLSTR_DATA_WIDTH-1:0] cluster;
    logic [CLSTR_RID_WIDTH-1:0]  rid;
  } clstr_mem_resp_t;

  // Tag width for an arbitrary port count; never narrower than one bit.
  function automatic int clstr_arb_port_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clstr_mem_arb_if.sv
// Bundle of all stream signals around the arbiter.
// Handshake rule for every stream: a word moves in a cycle where the consumer's
// read (or producer's write) strobe is 1; the strobe is only raised while the
// matching empty_n (or full_n) flag is 1, and the flag alone never moves data.
interface clstr_mem_arb_if
  import clstr_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = CLSTR_ARB_NUM_PORTS
) ();

  // requester side
  logic [NUM_PORTS-1:0]                           req_empty_n;
  logic [NUM_PORTS-1:0]                           req_read;
  logic [NUM_PORTS-1:0][CLSTR_MEM_REQ_WIDTH-1:0]  req_dout;

  // memory request stream
  logic                                           clstr_mem_req_full_n;
  logic                                           clstr_mem_req_write;
  logic [CLSTR_MEM_REQ_WIDTH-1:0]                 clstr_mem_req_din;

  // memory response stream
  logic                                           clstr_mem_resp_empty_n;
  logic                                           clstr_mem_resp_read;
  logic [CLSTR_MEM_RESP_WIDTH-1:0]                clstr_mem_resp_dout;

  // per-port response streams
  logic [NUM_PORTS-1:0]                           resp_full_n;
  logic [NUM_PORTS-1:0]                           resp_write;
  logic [NUM_PORTS-1:0][CLSTR_MEM_RESP_WIDTH-1:0] resp_din;

  // arbiter side: drives all strobes and data toward memory and requesters
  modport master (
    input  req_empty_n, req_dout,
    output req_read,
    input  clstr_mem_req_full_n,
    output clstr_mem_req_write, clstr_mem_req_din,
    input  clstr_mem_resp_empty_n, clstr_mem_resp_dout,
    output clstr_mem_resp_read,
    input  resp_full_n,
    output resp_write, resp_din
  );

  // surrounding system: requesters and memory
  modport slave (
    output req_empty_n, req_dout,
    input  req_read,
    output clstr_mem_req_full_n,
    input  clstr_mem_req_write, clstr_mem_req_din,
    output clstr_mem_resp_empty_n, clstr_mem_resp_dout,
    input  clstr_mem_resp_read,
    output resp_full_n,
    input  resp_write, resp_din
  );

endinterface

// File: rtl/clstr_mem_arb_tag_fifo.sv
// In-order tag FIFO: remembers which port issued each outstanding request.
// No bypass: a word pushed into an empty FIFO becomes head on the next cycle.
module clstr_mem_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/clstr_mem_arb.sv
// Round-robin arbiter sharing one cluster-memory port among NUM_PORTS
// requesters; responses are routed back in order using a tag FIFO.
module clstr_mem_arb
  import clstr_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = CLSTR_ARB_NUM_PORTS,
  parameter int TAG_DEPTH = CLSTR_ARB_TAG_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  clstr_mem_arb_if.master                        bus,
  output logic                                   busy,
  output logic                                   err_orphan,
  output logic [clstr_arb_port_width(NUM_PORTS)-1:0] o_dbg_rr_ptr,
  output logic [$clog2(TAG_DEPTH):0]             o_dbg_count
);

  localparam int PW = clstr_arb_port_width(NUM_PORTS);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [PW-1:0]        r_rr_ptr;
  logic                 r_err_orphan;

  int                   w_scan_idx;
  logic [PW-1:0]        w_scan_sel;
  logic                 w_found;
  logic [PW-1:0]        w_grant;
  logic                 w_issue_en;
  logic                 w_push;
  logic                 w_pop;
  logic [PW-1:0]        w_head;
  logic [CW-1:0]        w_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [NUM_PORTS-1:0] w_req_read;
  logic [NUM_PORTS-1:0] w_resp_write;

  clstr_mem_arb_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_push  (w_push),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Priority search starting at the round-robin pointer, wrapping at NUM_PORTS.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_scan_idx = 0;
    w_scan_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_scan_idx = int'(r_rr_ptr) + i;
      if (w_scan_idx >= NUM_PORTS) w_scan_idx = w_scan_idx - NUM_PORTS;
      w_scan_sel = PW'(w_scan_idx);
      if (!w_found && bus.req_empty_n[w_scan_sel]) begin
        w_found = 1'b1;
        w_grant = w_scan_sel;
      end
    end
  end

  // Issue needs memory space and a free tag slot; a same-cycle pop does not
  // free a slot early.
  assign w_issue_en = bus.clstr_mem_req_full_n & ~w_fifo_full;
  assign w_push     = w_issue_en & w_found;

  // Returns follow the head tag only; a full head port stalls every return.
  assign w_pop = ~w_fifo_empty & bus.clstr_mem_resp_empty_n & bus.resp_full_n[w_head];

  // One-hot strobes toward requesters and response streams.
  always_comb begin
    w_req_read   = '0;
    w_resp_write = '0;
    if (w_push) w_req_read[w_grant] = 1'b1;
    if (w_pop)  w_resp_write[w_head] = 1'b1;
  end

  assign bus.req_read            = w_req_read;
  assign bus.clstr_mem_req_write = w_push;
  assign bus.clstr_mem_req_din   = bus.req_dout[w_grant];
  assign bus.clstr_mem_resp_read = w_pop;
  assign bus.resp_write          = w_resp_write;
  assign bus.resp_din            = {NUM_PORTS{bus.clstr_mem_resp_dout}};

  // Pointer advances past the granted port; holds when nothing is granted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_grant == PW'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
    end
  end

  // Sticky flag for a response that has no outstanding tag to match.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_err_orphan <= 1'b0;
    end else if (bus.clstr_mem_resp_empty_n && w_fifo_empty && !w_push) begin
      r_err_orphan <= 1'b1;
    end
  end

  assign busy         = (w_count != '0);
  assign err_orphan   = r_err_orphan;
  assign o_dbg_rr_ptr = r_rr_ptr;
  assign o_dbg_count  = w_count;

endmodule

// File: tb/tb_clstr_mem_arb.sv
// Directed bench for clstr_mem_arb: 4 ports, 8 outstanding tags.
module tb_clstr_mem_arb;
  import clstr_mem_arb_pkg::*;

  logic       clk;
  logic       arst_n;
  logic       busy;
  logic       err_orphan;
  logic [1:0] dbg_rr;
  logic [3:0] dbg_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  clstr_mem_arb_if #(.NUM_PORTS(4)) bus ();

  clstr_mem_arb #(.NUM_PORTS(4), .TAG_DEPTH(8)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .bus          (bus),
    .busy         (busy),
    .err_orphan   (err_orphan),
    .o_dbg_rr_ptr (dbg_rr),
    .o_dbg_count  (dbg_count)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout: run did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] tgt;
    int ord6 [6]  = '{0, 1, 2, 3, 0, 1};
    int ord8 [8]  = '{2, 3, 0, 1, 2, 3, 0, 1};

    arst_n                     = 1'b0;
    bus.req_empty_n            = '0;
    bus.req_dout               = '0;
    bus.clstr_mem_req_full_n   = 1'b1;
    bus.clstr_mem_resp_empty_n = 1'b0;
    bus.clstr_mem_resp_dout    = '0;
    bus.resp_full_n            = 4'b1111;

    // reset state
    #12;
    chk("rst_req_read",   bus.req_read, 4'b0000);
    chk("rst_req_write",  bus.clstr_mem_req_write, 1'b0);
    chk("rst_resp_read",  bus.clstr_mem_resp_read, 1'b0);
    chk("rst_resp_write", bus.resp_write, 4'b0000);
    chk("rst_busy",       busy, 1'b0);
    chk("rst_err",        err_orphan, 1'b0);
    chk("rst_count",      dbg_count, 4'd0);
    arst_n = 1'b1;
    tick();

    // single port: port 2 sends {5,9}
    bus.req_empty_n = 4'b0100;
    bus.req_dout[2] = {16'd5, 8'd9};
    #1;
    chk("sp_req_read",  bus.req_read, 4'b0100);
    chk("sp_req_write", bus.clstr_mem_req_write, 1'b1);
    chk("sp_req_din",   bus.clstr_mem_req_din, 24'h000509);
    tick();
    bus.req_empty_n = 4'b0000;
    #1;
    chk("sp_busy",      busy, 1'b1);
    chk("sp_count",     dbg_count, 4'd1);
    chk("sp_rr",        dbg_rr, 2'd3);
    chk("sp_no_write",  bus.clstr_mem_req_write, 1'b0);
    bus.clstr_mem_resp_empty_n = 1'b1;
    bus.clstr_mem_resp_dout    = {32'hC, 8'd9};
    #1;
    chk("sp_resp_read",  bus.clstr_mem_resp_read, 1'b1);
    chk("sp_resp_write", bus.resp_write, 4'b0100);
    chk("sp_resp_din",   bus.resp_din[2], 40'h0000000C09);
    tick();
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("sp_busy_clr",   busy, 1'b0);
    chk("sp_resp_idle",  bus.resp_write, 4'b0000);

    // fresh reset, then all ports requesting
    arst_n = 1'b0;
    #1;
    arst_n = 1'b1;
    #1;
    bus.req_empty_n = 4'b1111;
    for (int p = 0; p < 4; p++) bus.req_dout[p] = {16'(p + 1), 8'(p)};
    for (int i = 0; i < 6; i++) begin
      #1;
      tgt = 4'b0001 << ord6[i];
      chk("rr_req_read", bus.req_read, tgt);
      chk("rr_req_din",  bus.clstr_mem_req_din, {16'(ord6[i] + 1), 8'(ord6[i])});
      exp_q.push_back(tgt);
      tick();
    end
    bus.req_empty_n = 4'b0000;
    #1;
    chk("rr_count6", dbg_count, 4'd6);
    bus.clstr_mem_resp_empty_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_resp_write", bus.resp_write, exp_q.pop_front());
      tick();
    end
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("rr_drained", dbg_count, 4'd0);
    chk("rr_no_err",  err_orphan, 1'b0);

    // outstanding limit: 8 grants then hold
    bus.req_empty_n = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      tgt = 4'b0001 << ord8[i];
      chk("lim_req_read", bus.req_read, tgt);
      exp_q.push_back(tgt);
      tick();
    end
    #1;
    chk("lim_count8",    dbg_count, 4'd8);
    chk("lim_held_read", bus.req_read, 4'b0000);
    chk("lim_held_wr",   bus.clstr_mem_req_write, 1'b0);
    bus.clstr_mem_resp_empty_n = 1'b1;
    #1;
    chk("lim_pop_read",  bus.clstr_mem_resp_read, 1'b1);
    chk("lim_pop_write", bus.resp_write, exp_q.pop_front());
    chk("lim_same_cyc",  bus.req_read, 4'b0000);
    tick();
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("lim_next_grant", bus.req_read, 4'b0100);
    chk("lim_count7",     dbg_count, 4'd7);
    exp_q.push_back(4'b0100);
    tick();
    bus.req_empty_n = 4'b0000;
    #1;
    chk("lim_refill", dbg_count, 4'd8);
    bus.clstr_mem_resp_empty_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lim_drain", bus.resp_write, exp_q.pop_front());
      tick();
    end
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("lim_empty", dbg_count, 4'd0);

    // head-of-line blocking: head port 1 full, next tag port 3
    bus.req_empty_n = 4'b0010;
    #1;
    chk("hol_grant1", bus.req_read, 4'b0010);
    tick();
    bus.req_empty_n = 4'b1000;
    #1;
    chk("hol_grant3", bus.req_read, 4'b1000);
    tick();
    bus.req_empty_n            = 4'b0000;
    bus.resp_full_n            = 4'b1101;
    bus.clstr_mem_resp_empty_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hol_no_read",  bus.clstr_mem_resp_read, 1'b0);
      chk("hol_no_write", bus.resp_write, 4'b0000);
      tick();
    end
    bus.resp_full_n = 4'b1111;
    #1;
    chk("hol_rel1", bus.resp_write, 4'b0010);
    tick();
    chk("hol_rel3", bus.resp_write, 4'b1000);
    tick();
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("hol_empty",  dbg_count, 4'd0);
    chk("hol_no_err", err_orphan, 1'b0);

    // orphan response
    bus.clstr_mem_resp_empty_n = 1'b1;
    #1;
    chk("orph_no_read", bus.clstr_mem_resp_read, 1'b0);
    chk("orph_not_yet", err_orphan, 1'b0);
    tick();
    bus.clstr_mem_resp_empty_n = 1'b0;
    #1;
    chk("orph_set", err_orphan, 1'b1);
    tick();
    chk("orph_sticky",  err_orphan, 1'b1);
    chk("orph_read_lo", bus.clstr_mem_resp_read, 1'b0);

    // reset with 3 outstanding
    bus.req_empty_n = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_grant", bus.req_read, 4'b0001 << i);
      tick();
    end
    bus.req_empty_n = 4'b0000;
    #1;
    chk("mid_count3", dbg_count, 4'd3);
    chk("mid_busy",   busy, 1'b1);
    arst_n = 1'b0;
    #1;
    chk("mid_req_read",   bus.req_read, 4'b0000);
    chk("mid_req_write",  bus.clstr_mem_req_write, 1'b0);
    chk("mid_resp_read",  bus.clstr_mem_resp_read, 1'b0);
    chk("mid_resp_write", bus.resp_write, 4'b0000);
    chk("mid_busy_clr",   busy, 1'b0);
    chk("mid_count0",     dbg_count, 4'd0);
    chk("mid_err_clr",    err_orphan, 1'b0);
    tick();
    arst_n = 1'b1;
    bus.req_empty_n = 4'b1111;
    #1;
    chk("mid_restart0", bus.req_read, 4'b0001);
    tick();
    bus.req_empty_n = 4'b0000;
    #1;
    chk("mid_rr1", dbg_rr, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
